// File: rtl/store_write_buffer_if.sv
// Data-memory write port of the store write buffer: one request per entry,
// held stable until the memory answers with mem_ack.
interface store_write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;

  modport master (
    output mem_req, mem_addr, mem_wdata, mem_be,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, mem_be,
    output mem_ack
  );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer: lane-formats stores from the store stage, queues them in a
// small FIFO and drains them in order to data memory over a req/ack handshake.
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [ADDR_W-1:0]          ALU_result,
  input  logic [DATA_W-1:0]          Write_data,
  input  logic [1:0]                 store_size,
  output logic                       stall,
  output logic                       misaligned,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  store_write_buffer_if.master       mem_bus
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_next;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W-3:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [3:0]        be_q   [DEPTH];

  logic              bad_align, accept, push, pop;
  logic [DATA_W-1:0] fmt_data;
  logic [3:0]        fmt_be;

  // Replicate the store data across every lane it could land in; the byte
  // enables select the lanes memory actually writes.
  always_comb begin
    bad_align = 1'b0;
    fmt_data  = Write_data;
    fmt_be    = 4'b1111;
    case (store_size)
      2'b00: begin
        fmt_data = {4{Write_data[7:0]}};
        fmt_be   = 4'b0001 << ALU_result[1:0];
      end
      2'b01: begin
        fmt_data  = {2{Write_data[15:0]}};
        fmt_be    = 4'b0011 << ALU_result[1:0];
        bad_align = ALU_result[0];
      end
      2'b10:   bad_align = |ALU_result[1:0];
      default: bad_align = 1'b1;
    endcase
  end

  assign stall  = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign accept = MemWrite && !stall;
  assign push   = accept && !bad_align;
  assign pop    = (state == BUSY) && mem_bus.mem_ack;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      misaligned <= 1'b0;
    end else begin
      count      <= count_next;
      misaligned <= accept && bad_align;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Entry storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= ALU_result[ADDR_W-1:2];
      data_q[wr_ptr] <= fmt_data;
      be_q[wr_ptr]   <= fmt_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // BUSY whenever anything is left after this edge's push/pop, which gives
  // back-to-back requests without a bubble.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (count_next != '0) ? BUSY : IDLE;
      BUSY:    state_next = (count_next != '0) ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_bus.mem_req   = 1'b0;
    mem_bus.mem_addr  = '0;
    mem_bus.mem_wdata = '0;
    mem_bus.mem_be    = 4'b0000;
    if (state == BUSY) begin
      mem_bus.mem_req   = 1'b1;
      mem_bus.mem_addr  = {addr_q[rd_ptr], 2'b00};
      mem_bus.mem_wdata = data_q[rd_ptr];
      mem_bus.mem_be    = be_q[rd_ptr];
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios then random traffic, all
// checked every cycle against a queue-based model of the buffer.
module tb_store_write_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [1:0]  store_size;
  logic        stall, misaligned, empty;
  logic [2:0]  count;

  int          n_checks = 0;
  int          n_fails  = 0;
  entry_t      model_q[$];
  logic        model_mis = 1'b0;
  logic [31:0] dut_log[$];
  int          saved_log;

  store_write_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (mem_write),
    .ALU_result (alu_result),
    .Write_data (write_data),
    .store_size (store_size),
    .stall      (stall),
    .misaligned (misaligned),
    .empty      (empty),
    .count      (count),
    .mem_bus    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a store is a queue entry; memory always sees the head.
  task automatic model_step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input logic ack, input logic rst);
    entry_t e;
    logic   bad;
    logic   full;
    if (!rst) begin
      model_q.delete();
      model_mis = 1'b0;
      return;
    end
    full = (model_q.size() == DEPTH);
    e.addr = {a[31:2], 2'b00};
    bad = 1'b0;
    case (sz)
      2'd0: begin e.wdata = {4{d[7:0]}};  e.be = 4'(1 << a[1:0]); end
      2'd1: begin e.wdata = {2{d[15:0]}}; e.be = 4'(3 << a[1:0]); bad = (a[0] != 1'b0); end
      2'd2: begin e.wdata = d;            e.be = 4'hF;            bad = (a[1:0] != 2'd0); end
      default: begin e.wdata = d;         e.be = 4'hF;            bad = 1'b1; end
    endcase
    if (model_q.size() != 0 && ack) void'(model_q.pop_front());
    if (mw && !full && !bad) model_q.push_back(e);
    model_mis = mw && !full && bad;
  endtask

  task automatic checkOutput();
    entry_t h;
    h.addr = 32'h0; h.wdata = 32'h0; h.be = 4'h0;
    if (model_q.size() != 0) h = model_q[0];
    check("count",      32'(count),         32'(model_q.size()));
    check("stall",      32'(stall),         32'(model_q.size() == DEPTH));
    check("empty",      32'(empty),         32'(model_q.size() == 0));
    check("misaligned", 32'(misaligned),    32'(model_mis));
    check("mem_req",    32'(bus.mem_req),   32'(model_q.size() != 0));
    check("mem_addr",   bus.mem_addr,       h.addr);
    check("mem_wdata",  bus.mem_wdata,      h.wdata);
    check("mem_be",     32'(bus.mem_be),    32'(h.be));
  endtask

  task automatic applyStimulus(input logic mw, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] sz, input logic ack, input logic rst);
    mem_write   = mw;
    alu_result  = a;
    write_data  = d;
    store_size  = sz;
    bus.mem_ack = ack;
    reset       = rst;
    if (bus.mem_req && ack && rst) dut_log.push_back(bus.mem_addr);
    @(posedge clk);
    model_step(mw, a, d, sz, ack, rst);
    #1;
    checkOutput();
  endtask

  initial begin
    reset = 1'b0; mem_write = 1'b0; alu_result = '0; write_data = '0;
    store_size = 2'd0; bus.mem_ack = 1'b0;

    $display("[TB] reset and single word store");
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    check("rst_empty", 32'(empty), 32'd1);
    applyStimulus(1, 32'h10, 32'h0000_000B, 2'd2, 0, 1);
    check("t1_req",   32'(bus.mem_req), 32'd1);
    check("t1_addr",  bus.mem_addr,     32'h10);
    check("t1_wdata", bus.mem_wdata,    32'h0000_000B);
    check("t1_be",    32'(bus.mem_be),  32'hF);
    applyStimulus(0, 0, 0, 0, 1, 1);
    check("t1_idle", 32'(bus.mem_req), 32'd0);

    $display("[TB] byte and half lanes");
    applyStimulus(1, 32'h13, 32'h0000_00A5, 2'd0, 1, 1);
    check("t2_addr0",  bus.mem_addr,    32'h10);
    check("t2_wdata0", bus.mem_wdata,   32'hA5A5_A5A5);
    check("t2_be0",    32'(bus.mem_be), 32'h8);
    applyStimulus(1, 32'h22, 32'h0000_BEEF, 2'd1, 1, 1);
    check("t2_addr1",  bus.mem_addr,    32'h20);
    check("t2_wdata1", bus.mem_wdata,   32'hBEEF_BEEF);
    check("t2_be1",    32'(bus.mem_be), 32'hC);
    applyStimulus(0, 0, 0, 0, 1, 1);

    $display("[TB] full and stall");
    dut_log.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'(4 * i), 32'(i), 2'd2, 0, 1);
    check("t3_count_full", 32'(count), 32'd4);
    check("t3_stall",      32'(stall), 32'd1);
    applyStimulus(1, 32'h10, 32'h4, 2'd2, 0, 1);
    applyStimulus(1, 32'h10, 32'h4, 2'd2, 1, 1);
    check("t3_count_pop", 32'(count), 32'd3);
    applyStimulus(1, 32'h10, 32'h4, 2'd2, 0, 1);
    check("t3_count_refill", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    check("t3_drained", 32'(dut_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < dut_log.size(); i++)
      check($sformatf("t3_order%0d", i), dut_log[i], 32'(4 * i));

    $display("[TB] misaligned stores");
    applyStimulus(1, 32'h6, 32'h1, 2'd2, 0, 1);
    check("t4_mis_word", 32'(misaligned), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    check("t4_mis_clear", 32'(misaligned), 32'd0);
    applyStimulus(1, 32'h1, 32'h1, 2'd1, 0, 1);
    check("t4_mis_half", 32'(misaligned), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 32'h0, 32'h1, 2'd3, 0, 1);
    check("t4_mis_rsvd", 32'(misaligned), 32'd1);
    check("t4_count",    32'(count),      32'd0);
    check("t4_req",      32'(bus.mem_req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] push during ack");
    applyStimulus(1, 32'h40, 32'h1111_1111, 2'd2, 0, 1);
    applyStimulus(1, 32'h44, 32'h2222_2222, 2'd2, 1, 1);
    check("t5_count", 32'(count),        32'd1);
    check("t5_req",   32'(bus.mem_req),  32'd1);
    check("t5_addr",  bus.mem_addr,      32'h44);
    applyStimulus(0, 0, 0, 0, 1, 1);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'(32'h80 + 4 * i), 32'(i), 2'd2, 0, 1);
    saved_log = dut_log.size();
    applyStimulus(0, 0, 0, 0, 1, 0);
    check("t6_req",   32'(bus.mem_req), 32'd0);
    check("t6_count", 32'(count),       32'd0);
    check("t6_empty", 32'(empty),       32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 1);
    check("t6_no_write", 32'(dut_log.size()), 32'(saved_log));

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    {$urandom_range(0, 255) << 2 | $urandom_range(0, 3)},
                    $urandom,
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 63) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 0, 0, 0, 1, 1);
    check("final_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
